adder_arbiter: RTL and testbench

Shares one ripple-carry Adder instance (BITS wide) among NREQ requesters, such as the PC incrementer, branch target unit and ALU-assist ports.
- Round-robin arbitration, valid/ready handshake on each request port.
- ADD/SUB select per request.
- Registered single-entry result buffer with ID tag, carry and signed-overflow flags.
- Sits between requesting pipeline units and the shared adder datapath.

---
 rtl/adder_pkg.sv | 14 +
 rtl/adder.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/adder_arbiter.sv | 125 ++++++++++++
 tb/tb_adder_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and types for the shared-adder arbiter
package adder_pkg;

    localparam int DEFAULT_BITS = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - ripple-carry adder shared by all requesters
module Adder #(
    parameter int BITS = 64
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);

    logic [BITS:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < BITS; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[BITS];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic [IDW-1:0] idx;

    // Walk ptr, ptr+1, ... with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + 32'(k)) % NREQ);
            if (enable && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin access to one shared adder with a one-entry result buffer
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [BITS-1:0]      resp_sum,
    output logic                 resp_cout,
    output logic                 resp_ovf
);

    buf_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [BITS-1:0] resp_sum_q, resp_sum_d;
    logic            resp_cout_q, resp_cout_d;
    logic            resp_ovf_q, resp_ovf_d;

    logic [BITS-1:0] a_arr [NREQ];
    logic [BITS-1:0] b_arr [NREQ];

    logic            can_accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_grant;

    logic [BITS-1:0] sel_a, sel_b, b_eff, add_sum;
    logic            sel_op, add_cin, add_cout, add_ovf;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*BITS +: BITS];
        assign b_arr[i] = req_b[i*BITS +: BITS];
    end

    // A full buffer can still accept when it is being drained this same cycle.
    assign can_accept = (state_q == ST_EMPTY) || resp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (can_accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    assign sel_a   = a_arr[grant_idx];
    assign sel_b   = b_arr[grant_idx];
    assign sel_op  = req_op[grant_idx];
    assign b_eff   = (sel_op == OP_SUB) ? ~sel_b : sel_b;
    assign add_cin = (sel_op == OP_SUB);

    Adder #(
        .BITS (BITS)
    ) u_adder (
        .a    (sel_a),
        .b    (b_eff),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ovf = (sel_a[BITS-1] == b_eff[BITS-1]) && (add_sum[BITS-1] != sel_a[BITS-1]);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        resp_id_d   = resp_id_q;
        resp_sum_d  = resp_sum_q;
        resp_cout_d = resp_cout_q;
        resp_ovf_d  = resp_ovf_q;
        if (any_grant) begin
            state_d     = ST_FULL;
            ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            resp_id_d   = grant_idx;
            resp_sum_d  = add_sum;
            resp_cout_d = add_cout;
            resp_ovf_d  = add_ovf;
        end else if (state_q == ST_FULL && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            ptr_q       <= '0;
            resp_id_q   <= '0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
            resp_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            resp_id_q   <= resp_id_d;
            resp_sum_q  <= resp_sum_d;
            resp_cout_q <= resp_cout_d;
            resp_ovf_q  <= resp_ovf_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign resp_ovf   = resp_ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter
module tb_adder_arbiter;

    localparam int BITS = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [BITS-1:0] sum;
        logic            cout;
        logic            ovf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*BITS-1:0] req_a;
    logic [NREQ*BITS-1:0] req_b;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [BITS-1:0]      resp_sum;
    logic                 resp_cout;
    logic                 resp_ovf;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    adder_arbiter #(
        .BITS (BITS),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input logic [BITS-1:0] sum, input logic cout, input logic ovf);
        exp_t e;
        e.id   = IDW'(id);
        e.sum  = sum;
        e.cout = cout;
        e.ovf  = ovf;
        return e;
    endfunction

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got id=%0d sum=0x%0h, nothing expected", resp_id, resp_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp", 128'({resp_id, resp_sum, resp_cout, resp_ovf}), 128'(e));
            end
        end
    end

    task automatic set_req(input int id, input logic op, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        req_op[id]           = op;
        req_a[id*BITS +: BITS] = a;
        req_b[id*BITS +: BITS] = b;
    endtask

    task automatic do_req(input string name, input int id, input logic op,
                          input logic [BITS-1:0] a, input logic [BITS-1:0] b, input exp_t e);
        @(posedge clk); #1;
        set_req(id, op, a, b);
        req_valid = NREQ'(1) << id;
        @(negedge clk);
        check({name, "_ready"}, 128'(req_ready), 128'(NREQ'(1) << id));
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_drain"}, 128'(resp_valid), 128'(0));
    endtask

    logic [BITS-1:0] rr_a   [NREQ] = '{64'd100, 64'd101, 64'd102, 64'd103};
    logic [BITS-1:0] rr_b   [NREQ] = '{64'd0, 64'd10, 64'd20, 64'd30};
    logic [BITS-1:0] rr_sum [NREQ] = '{64'd100, 64'd111, 64'd122, 64'd133};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("in_reset", 128'({resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, req_ready}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle", 128'({resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, req_ready}), 128'(0));
        end

        do_req("add_5_7",  2, 1'b0, 64'd5, 64'd7, mk(2, 64'd12, 1'b0, 1'b0));
        do_req("sub_3_5",  0, 1'b1, 64'd3, 64'd5, mk(0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
        do_req("add_ovf",  1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, mk(1, 64'h8000_0000_0000_0000, 1'b0, 1'b1));
        do_req("add_wrap", 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, mk(2, 64'd0, 1'b1, 1'b0));
        do_req("sub_5_3",  1, 1'b1, 64'd5, 64'd3, mk(1, 64'd2, 1'b1, 1'b0));
        do_req("sub_ovf",  3, 1'b1, 64'h8000_0000_0000_0000, 64'd1, mk(3, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));

        // All four requesters continuously valid; pointer is 0 after the last grant to 3.
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, rr_a[i], rr_b[i]);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 128'(req_ready), 128'(NREQ'(1) << (k % NREQ)));
            sb.push_back(mk(k % NREQ, rr_sum[k % NREQ], 1'b0, 1'b0));
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Backpressure with a buffered id=1 result, then same-edge replacement by id=3.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_req(1, 1'b0, 64'h8, 64'h8);
        req_valid = 4'b0010;
        @(negedge clk);
        check("bp_load_ready", 128'(req_ready), 128'(4'b0010));
        sb.push_back(mk(1, 64'h10, 1'b0, 1'b0));
        @(posedge clk); #1;
        set_req(3, 1'b1, 64'h20, 64'h3);
        req_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold", 128'({req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_ovf}),
                  128'({4'b0000, 1'b1, 2'd1, 64'h10, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_replace_ready", 128'(req_ready), 128'(4'b1000));
        sb.push_back(mk(3, 64'h1D, 1'b1, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Buffer a result from requester 0 (pointer moves to 1), then reset mid-cycle.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_req(0, 1'b0, 64'd1, 64'd1);
        req_valid = 4'b0001;
        @(negedge clk);
        check("rst_load_ready", 128'(req_ready), 128'(4'b0001));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("rst_full", 128'(resp_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 128'({resp_valid, resp_id, resp_sum, resp_cout, resp_ovf}), 128'(0));
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 1'b0, 64'd2, 64'd3);
        set_req(1, 1'b1, 64'd10, 64'd4);
        req_valid = 4'b0011;
        @(negedge clk);
        check("post_rst_grant0", 128'(req_ready), 128'(4'b0001));
        sb.push_back(mk(0, 64'd5, 1'b0, 1'b0));
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk);
        check("post_rst_grant1", 128'(req_ready), 128'(4'b0010));
        sb.push_back(mk(1, 64'd6, 1'b1, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(negedge clk);

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
